// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and encodings for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_ILLEGAL  = 2'b10;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Byte-lane steering for stores, extraction/extension for loads,
//               and legality/alignment checks of a memory access.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic        write,
    input  logic [2:0]  func3,
    input  logic [1:0]  lane,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shift = rdata >> {lane, 3'b000};
    assign w_byte  = w_shift[7:0];
    assign w_half  = lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be         = 4'b1111;
        wdata      = rs2;
        load_ext   = rdata;
        misaligned = 1'b0;
        illegal    = 1'b1;
        case (func3)
            F3_B: begin
                illegal  = 1'b0;
                load_ext = {{24{w_byte[7]}}, w_byte};
                if (write) begin
                    be    = 4'b0001 << lane;
                    wdata = {4{rs2[7:0]}};
                end
            end
            F3_H: begin
                illegal    = 1'b0;
                misaligned = lane[0];
                load_ext   = {{16{w_half[15]}}, w_half};
                if (write) begin
                    be    = 4'b0011 << lane;
                    wdata = {2{rs2[15:0]}};
                end
            end
            F3_W: begin
                illegal    = 1'b0;
                misaligned = (lane != 2'b00);
            end
            // Unsigned variants exist only for loads
            F3_BU: begin
                illegal  = write;
                load_ext = {24'd0, w_byte};
            end
            F3_HU: begin
                illegal    = write;
                misaligned = lane[0];
                load_ext   = {16'd0, w_half};
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle load/store unit with req/ack memory handshake,
//               core stall generation, timeout and access fault reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_func3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic [1:0]  fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_write;
    logic [2:0]       r_func3;
    logic [1:0]       r_lane;
    logic [1:0]       w_fault_nxt;

    logic             w_sel_write;
    logic [2:0]       w_sel_func3;
    logic [1:0]       w_sel_lane;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load_ext;
    logic             w_misaligned;
    logic             w_illegal;

    // While an access is outstanding the aligner works from the latched request
    assign w_sel_write = (r_state == ST_IDLE) ? req_write      : r_write;
    assign w_sel_func3 = (r_state == ST_IDLE) ? req_func3      : r_func3;
    assign w_sel_lane  = (r_state == ST_IDLE) ? req_addr[1:0]  : r_lane;

    lsu_align u_align (
        .write      (w_sel_write),
        .func3      (w_sel_func3),
        .lane       (w_sel_lane),
        .rs2        (req_wdata),
        .rdata      (mem_rdata),
        .be         (w_be),
        .wdata      (w_wdata),
        .load_ext   (w_load_ext),
        .misaligned (w_misaligned),
        .illegal    (w_illegal)
    );

    assign stall = req_valid & (r_state != ST_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fault_nxt = FLT_NONE;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_illegal) begin
                        w_state_nxt = ST_RESP;
                        w_fault_nxt = FLT_ILLEGAL;
                    end else if (w_misaligned) begin
                        w_state_nxt = ST_RESP;
                        w_fault_nxt = FLT_MISALIGN;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ack) begin
                    w_state_nxt = ST_RESP;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = ST_RESP;
                    w_fault_nxt = FLT_TIMEOUT;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_func3    <= 3'b000;
            r_lane     <= 2'b00;
            load_valid <= 1'b0;
            load_data  <= 32'd0;
            fault      <= FLT_NONE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 30'd0;
            mem_be     <= 4'b0000;
            mem_wdata  <= 32'd0;
        end else begin
            load_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_func3 <= req_func3;
                        r_lane  <= req_addr[1:0];
                        r_cnt   <= '0;
                        fault   <= w_fault_nxt;
                        if (w_state_nxt == ST_BUSY) begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= req_addr[31:2];
                            mem_be    <= w_be;
                            mem_wdata <= w_wdata;
                        end else if (!req_write) begin
                            load_data <= 32'd0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_state_nxt == ST_RESP) begin
                        mem_req <= 1'b0;
                        fault   <= w_fault_nxt;
                        if (!r_write) begin
                            load_data  <= mem_ack ? w_load_ext : 32'd0;
                            load_valid <= mem_ack;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: fault <= FLT_NONE;
            endcase
        end
    end

endmodule
`default_nettype wire
